// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types and address-field width helpers for icache_assoc
package icache_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned log2c(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Vector width for a field that may be zero bits wide.
  function automatic int unsigned nz(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic int unsigned offset_w(input int unsigned block_words);
    return log2c(block_words);
  endfunction

  function automatic int unsigned index_w(input int unsigned sets);
    return log2c(sets);
  endfunction

  function automatic int unsigned tag_w(input int unsigned sets, input int unsigned block_words);
    return 30 - offset_w(block_words) - index_w(sets);
  endfunction

endpackage

// File: rtl/icache_assoc_lru_ages.sv
// rtl/icache_assoc_lru_ages.sv - per-set true-LRU age tracking with touch and victim lookup
module lru_ages
  import icache_pkg::*;
#(
  parameter int unsigned SETS = 8,
  parameter int unsigned WAYS = 2
) (
  input  logic                               CLK,
  input  logic                               nRST,
  input  logic                               touch_i,
  input  logic [nz(index_w(SETS))-1:0]       touch_set_i,
  input  logic [nz(log2c(WAYS))-1:0]         touch_way_i,
  input  logic [nz(index_w(SETS))-1:0]       victim_set_i,
  output logic [nz(log2c(WAYS))-1:0]         victim_way_o
);

  localparam int unsigned WW = nz(log2c(WAYS));

  if (WAYS == 1) begin : g_direct
    logic unused_lru;
    assign unused_lru   = ^{CLK, nRST, touch_i, touch_set_i, touch_way_i, victim_set_i};
    assign victim_way_o = '0;
  end else begin : g_lru
    logic [WW-1:0] age_q [SETS][WAYS];

    // Touched way becomes age 0; ways younger than it grow one older.
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        for (int s = 0; s < int'(SETS); s++) begin
          for (int w = 0; w < int'(WAYS); w++) begin
            age_q[s][w] <= WW'(w);
          end
        end
      end else if (touch_i) begin
        for (int w = 0; w < int'(WAYS); w++) begin
          if (WW'(w) == touch_way_i) begin
            age_q[touch_set_i][w] <= '0;
          end else if (age_q[touch_set_i][w] < age_q[touch_set_i][touch_way_i]) begin
            age_q[touch_set_i][w] <= age_q[touch_set_i][w] + 1'b1;
          end
        end
      end
    end

    // The oldest way in the set (age WAYS-1) is the replacement candidate.
    always_comb begin
      victim_way_o = '0;
      for (int w = 0; w < int'(WAYS); w++) begin
        if (age_q[victim_set_i][w] == WW'(WAYS - 1)) victim_way_o = WW'(w);
      end
    end
  end

endmodule

// File: rtl/icache_assoc.sv
// rtl/icache_assoc.sv - parametrised set-associative instruction cache with block fill FSM
module icache_assoc
  import icache_pkg::*;
#(
  parameter int unsigned SETS        = 8,
  parameter int unsigned WAYS        = 2,
  parameter int unsigned BLOCK_WORDS = 2,
  parameter int unsigned CPUID       = 0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        iflush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int unsigned BO      = offset_w(BLOCK_WORDS);
  localparam int unsigned IX      = index_w(SETS);
  localparam int unsigned TAG_W   = tag_w(SETS, BLOCK_WORDS);
  localparam int unsigned OW      = nz(BO);
  localparam int unsigned WW      = nz(log2c(WAYS));
  localparam int unsigned IDX_LSB = 2 + BO;
  localparam int unsigned TAG_LSB = 2 + BO + IX;

  typedef struct packed {
    logic                         valid;
    logic [TAG_W-1:0]             tag;
    logic [BLOCK_WORDS-1:0][31:0] data;
  } line_t;

  // CPUID only selects this cache's slot in the controller arrays at the parent level.
  logic [31:0] unused_cpuid;
  assign unused_cpuid = 32'(CPUID);

  line_t         lines_q [SETS][WAYS];
  icache_state_t state_q, state_d;
  logic [OW-1:0] cnt_q, cnt_d;
  logic [31:0]   base_q, base_d;
  logic [IX-1:0] idx_q, idx_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [WW-1:0] vic_q, vic_d;

  logic [OW-1:0]    req_off;
  logic [IX-1:0]    req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             hit_any, has_inv;
  logic [WW-1:0]    hit_way, inv_way, lru_vic, miss_vic;
  logic             flush_all, miss_start, word_we, fill_done;
  logic             touch;
  logic [IX-1:0]    touch_set;
  logic [WW-1:0]    touch_way;

  assign req_off = OW'((imemaddr >> 2) & 32'(BLOCK_WORDS - 1));
  assign req_idx = IX'(imemaddr >> IDX_LSB);
  assign req_tag = TAG_W'(imemaddr >> TAG_LSB);

  // Tag compare across the ways of the addressed set, plus lowest invalid way for refill.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (lines_q[req_idx][w].valid && (lines_q[req_idx][w].tag == req_tag)) begin
        hit_any = 1'b1;
        hit_way = WW'(w);
      end
    end
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!lines_q[req_idx][w].valid) begin
        has_inv = 1'b1;
        inv_way = WW'(w);
      end
    end
  end

  assign miss_vic  = has_inv ? inv_way : lru_vic;
  assign touch     = ihit || fill_done;
  assign touch_set = fill_done ? idx_q : req_idx;
  assign touch_way = fill_done ? vic_q : hit_way;

  lru_ages #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_lru (
    .CLK          (CLK),
    .nRST         (nRST),
    .touch_i      (touch),
    .touch_set_i  (touch_set),
    .touch_way_i  (touch_way),
    .victim_set_i (req_idx),
    .victim_way_o (lru_vic)
  );

  // Next-state and outputs: hits served from IDLE, FETCH walks the block one word per accept.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    idx_d      = idx_q;
    tag_d      = tag_q;
    vic_d      = vic_q;
    flush_all  = 1'b0;
    miss_start = 1'b0;
    word_we    = 1'b0;
    fill_done  = 1'b0;
    ihit       = 1'b0;
    imemload   = '0;
    iREN       = 1'b0;
    iaddr      = '0;
    case (state_q)
      IDLE: begin
        if (iflush) begin
          flush_all = 1'b1;
        end else if (imemREN) begin
          if (hit_any) begin
            ihit     = 1'b1;
            imemload = lines_q[req_idx][hit_way].data[req_off];
          end else begin
            miss_start = 1'b1;
            state_d    = FETCH;
            base_d     = imemaddr & ~(32'(BLOCK_WORDS) * 32'd4 - 32'd1);
            idx_d      = req_idx;
            tag_d      = req_tag;
            vic_d      = miss_vic;
            cnt_d      = '0;
          end
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = base_q + (32'(cnt_q) << 2);
        if (iflush) begin
          flush_all = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else if (!iwait) begin
          word_we = 1'b1;
          if (cnt_q == OW'(BLOCK_WORDS - 1)) begin
            fill_done = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state and captured miss context.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      idx_q   <= '0;
      tag_q   <= '0;
      vic_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      tag_q   <= tag_d;
      vic_q   <= vic_d;
    end
  end

  // Line storage: victim invalidated at miss, words streamed in, tag/valid committed on last word.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int s = 0; s < int'(SETS); s++) begin
        for (int w = 0; w < int'(WAYS); w++) begin
          lines_q[s][w] <= '0;
        end
      end
    end else if (flush_all) begin
      for (int s = 0; s < int'(SETS); s++) begin
        for (int w = 0; w < int'(WAYS); w++) begin
          lines_q[s][w].valid <= 1'b0;
        end
      end
    end else begin
      if (miss_start) lines_q[req_idx][miss_vic].valid <= 1'b0;
      if (word_we) lines_q[idx_q][vic_q].data[cnt_q] <= iload;
      if (fill_done) begin
        lines_q[idx_q][vic_q].tag   <= tag_q;
        lines_q[idx_q][vic_q].valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_icache_assoc.sv
// tb/tb_icache_assoc.sv - self-checking bench for icache_assoc against a recency-list cache model
module tb_icache_assoc;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        iflush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  int n_asserts = 0;
  int n_fail    = 0;
  int wait_n    = 0;
  int wcnt      = 0;

  // Model: per set, resident tags ordered most-recent first (8 sets, 2 ways, 2-word blocks).
  logic [25:0] rtag [8][2];
  int          rcnt [8];

  icache_assoc #(
    .SETS        (8),
    .WAYS        (2),
    .BLOCK_WORDS (2),
    .CPUID       (0)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .iflush   (iflush),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[17:2], ~a[17:2]} ^ 32'h5A3C_96E1;
  endfunction

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Memory: each word is held busy for wait_n cycles before it is accepted.
  always @(posedge CLK) begin
    if (!iREN) wcnt <= wait_n;
    else if (wcnt != 0) wcnt <= wcnt - 1;
    else wcnt <= wait_n;
  end
  assign iwait = iREN && (wcnt != 0);
  assign iload = iREN ? mem_word(iaddr) : 32'hDEAD_BEEF;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int m_find(input logic [31:0] a);
    int s;
    s = int'(a[5:3]);
    for (int i = 0; i < rcnt[s]; i++) begin
      if (rtag[s][i] == a[31:6]) return i;
    end
    return -1;
  endfunction

  task automatic m_touch(input int s, input int p);
    logic [25:0] t;
    t = rtag[s][p];
    for (int i = p; i > 0; i--) rtag[s][i] = rtag[s][i-1];
    rtag[s][0] = t;
  endtask

  task automatic m_insert(input int s, input logic [25:0] tg);
    if (rcnt[s] < 2) rcnt[s]++;
    for (int i = rcnt[s] - 1; i > 0; i--) rtag[s][i] = rtag[s][i-1];
    rtag[s][0] = tg;
  endtask

  task automatic m_flush();
    for (int s = 0; s < 8; s++) rcnt[s] = 0;
  endtask

  task automatic do_fetch(input logic [31:0] a);
    int          pos, cyc, k, s;
    logic [31:0] base;
    bit          done;
    @(negedge CLK);
    imemREN  = 1'b1;
    imemaddr = a;
    #1;
    s   = int'(a[5:3]);
    pos = m_find(a);
    chk("hit_idle", 32'(ihit), 32'(pos >= 0));
    if (pos >= 0) begin
      chk("hit_data", imemload, mem_word(a));
      chk("hit_no_iren", 32'(iREN), 32'd0);
      m_touch(s, pos);
    end else begin
      chk("miss_load_zero", imemload, 32'd0);
      base = a & ~32'h7;
      cyc  = 0;
      k    = 0;
      done = 1'b0;
      while (!done && cyc < 60) begin
        @(negedge CLK);
        #1;
        cyc++;
        if (ihit) begin
          done = 1'b1;
        end else begin
          chk("fill_iren", 32'(iREN), 32'd1);
          chk("fill_iaddr", iaddr, base + 32'(4 * k));
          chk("fill_load_zero", imemload, 32'd0);
          if (!iwait) k++;
        end
      end
      chk("miss_latency", 32'(cyc), 32'(2 * (wait_n + 1) + 1));
      chk("refill_data", imemload, mem_word(a));
      chk("refill_iren", 32'(iREN), 32'd0);
      m_insert(s, a[31:6]);
    end
  endtask

  task automatic do_flush(input logic [31:0] a);
    @(negedge CLK);
    imemREN  = 1'b1;
    imemaddr = a;
    iflush   = 1'b1;
    #1;
    chk("flush_ihit", 32'(ihit), 32'd0);
    chk("flush_iren", 32'(iREN), 32'd0);
    @(negedge CLK);
    iflush  = 1'b0;
    imemREN = 1'b0;
    #1;
    chk("post_flush_iren", 32'(iREN), 32'd0);
    m_flush();
  endtask

  task automatic idle_cycle();
    @(negedge CLK);
    imemREN = 1'b0;
    #1;
    chk("idle_ihit", 32'(ihit), 32'd0);
    chk("idle_iren", 32'(iREN), 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = (32'($urandom_range(0, 5)) << 6) | (32'($urandom_range(0, 7)) << 3) |
        (32'($urandom_range(0, 1)) << 2) | 32'($urandom_range(0, 3));
    return a;
  endfunction

  // Directed steps from reset through the documented scenarios, then a randomized run.
  initial begin
    m_flush();
    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = '0;
    iflush   = 1'b0;
    repeat (3) @(negedge CLK);
    imemREN  = 1'b1;
    imemaddr = 32'h40;
    #1;
    chk("rst_ihit", 32'(ihit), 32'd0);
    chk("rst_iren", 32'(iREN), 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    chk("rst_imemload", imemload, 32'd0);
    @(negedge CLK);
    imemREN = 1'b0;
    nRST    = 1'b1;

    // Cold miss with no wait states, then the neighbouring word hits.
    wait_n = 0;
    do_fetch(32'h40);
    do_fetch(32'h44);

    // Three wait cycles per word: nine cycles from request to hit.
    wait_n = 3;
    do_fetch(32'h1040);
    do_fetch(32'h1044);

    // LRU eviction within set 0.
    wait_n = 0;
    do_flush(32'h40);
    do_fetch(32'h000);
    do_fetch(32'h040);
    do_fetch(32'h000);
    do_fetch(32'h080);
    do_fetch(32'h000);
    do_fetch(32'h080);
    do_fetch(32'h040);

    // Flush in IDLE invalidates lines that were hitting.
    do_flush(32'h0);
    do_fetch(32'h40);
    do_fetch(32'h88);
    do_fetch(32'h40);
    do_fetch(32'h8C);
    do_flush(32'h40);
    do_fetch(32'h40);
    do_fetch(32'h88);

    // Flush during the second word of a fill aborts it.
    do_flush(32'h0);
    @(negedge CLK);
    imemREN  = 1'b1;
    imemaddr = 32'h40;
    #1;
    chk("abort_miss", 32'(ihit), 32'd0);
    @(negedge CLK);
    #1;
    chk("abort_w0_iaddr", iaddr, 32'h40);
    @(negedge CLK);
    iflush = 1'b1;
    #1;
    chk("abort_w1_iaddr", iaddr, 32'h44);
    chk("abort_w1_iren", 32'(iREN), 32'd1);
    @(negedge CLK);
    iflush  = 1'b0;
    imemREN = 1'b0;
    #1;
    chk("abort_iren_drop", 32'(iREN), 32'd0);
    m_flush();
    do_fetch(32'h40);

    // Address moves mid-fill; the captured block still completes.
    do_flush(32'h0);
    @(negedge CLK);
    imemREN  = 1'b1;
    imemaddr = 32'h40;
    #1;
    chk("move_miss", 32'(ihit), 32'd0);
    @(negedge CLK);
    imemaddr = 32'h100;
    #1;
    chk("move_w0_iaddr", iaddr, 32'h40);
    chk("move_w0_ihit", 32'(ihit), 32'd0);
    chk("move_w0_load", imemload, 32'd0);
    @(negedge CLK);
    #1;
    chk("move_w1_iaddr", iaddr, 32'h44);
    chk("move_w1_ihit", 32'(ihit), 32'd0);
    @(negedge CLK);
    imemREN = 1'b0;
    #1;
    chk("move_done_iren", 32'(iREN), 32'd0);
    m_insert(0, 26'h1);
    do_fetch(32'h100);
    do_fetch(32'h40);

    // Randomized accesses over a small address pool to force conflicts.
    for (int i = 0; i < 250; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        do_flush(rand_addr());
      end else if (r == 1) begin
        idle_cycle();
      end else begin
        wait_n = int'($urandom_range(0, 2));
        do_fetch(rand_addr());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_assoc.md
Name: icache_assoc

Overview:
Parametrised set-associative instruction cache. Successor to the direct-mapped, one-word-per-line icache.
- Sits between the datapath fetch port and the memory controller, on the same signal set as the datapath_cache/cache_control icache modports.
- Adds configurable sets, ways and multi-word blocks, LRU replacement, a miss FSM with a word-fill counter, and a whole-cache invalidate.

Parameters:
SETS, 8, number of sets; power of two, 2..64
WAYS, 2, associativity; 1, 2 or 4
BLOCK_WORDS, 2, 32-bit words per line; 1, 2 or 4
CPUID, 0, index into the controller's per-CPU iREN/iwait/iload/iaddr arrays

Ports:
CLK  in  1  clock
nRST  in  1  reset, asynchronous, active-low
imemREN  in  1  datapath fetch request
imemaddr  in  32  fetch byte address; bits [1:0] ignored
iflush  in  1  single-cycle pulse: invalidate all lines
ihit  out  1  imemload valid this cycle
imemload  out  32  instruction word
iREN  out  1  memory read request (drives iREN[CPUID])
iaddr  out  32  memory word address (drives iaddr[CPUID])
iwait  in  1  memory busy; word accepted when iREN && !iwait
iload  in  32  memory read data

Behaviour:
- Address split, with BO = log2(BLOCK_WORDS) and IX = log2(SETS):
  - word offset = [2+BO-1:2]
  - index = [2+BO+IX-1:2+BO]
  - tag = [31:2+BO+IX]
  - Defaults give offset [2], index [5:3], tag [31:6] (26 bits).
- Storage per way per set: valid bit, tag, BLOCK_WORDS data words. Per set: log2(WAYS)-bit age per way for true LRU; age 0 = MRU.
- Reset:
  - State IDLE, all valid 0, all ages initialised to way index, fill counter 0.
  - Outputs: ihit 0, iREN 0, iaddr 0, imemload 0.
  - Reset takes effect mid-fill immediately: the partial line stays invalid.
- States: IDLE, FETCH.
- IDLE:
  - ihit = imemREN && any way has valid && tag match; combinational, zero-latency.
  - imemload = the hitting way's word at the offset; 0 when no hit.
  - On the rising CLK with ihit, the hit way becomes MRU. Ways younger than it age by 1.
  - Miss (imemREN && !ihit && !iflush) -> FETCH. Capture:
    - block base address: imemaddr with offset and byte bits cleared
    - index and tag
    - victim = lowest-numbered invalid way, else the way with age WAYS-1
  - Victim valid is cleared on entry.
- FETCH:
  - ihit = 0 and imemload = 0, regardless of imemaddr.
  - iREN = 1; iaddr = base + 4*cnt.
  - Each cycle with !iwait: write iload into victim word cnt, cnt++.
  - On the word cnt = BLOCK_WORDS-1 accepted:
    - write tag, set valid, victim becomes MRU
    - cnt -> 0, -> IDLE
  - The following cycle hits if imemaddr is unchanged, so miss latency = fill cycles + 1.
- imemREN deasserting or imemaddr changing during FETCH does not abort the fill. The captured block completes.
- iflush in IDLE: all valid bits clear at the next edge. ihit is forced 0 in the flush cycle and no miss is started.
- iflush in FETCH: the fill aborts; iREN drops at the next edge; valid stays 0; cnt -> 0; -> IDLE with all lines invalid. A word accepted in the same cycle is discarded.
- WAYS = 1: age logic is absent; the victim is always way 0. BLOCK_WORDS = 1: a fill is a single accepted word.
- Ages never exceed WAYS-1. Ages within a set always form a permutation of 0..WAYS-1.

Decomposition:
- Shared package icache_pkg:
  - icache_state_t enum {IDLE, FETCH}
  - width-computing functions for tag, index and offset
  - line record typedef (valid, tag, data array), parametrised through the package function widths
- One sub-module, lru_ages (SETS, WAYS): age storage, touch(set, way) update, victim(set) output. It is unit-testable on its own.

Test Plan:
- Cold miss, defaults. imemREN=1, imemaddr=0x0000_0040, iwait=0 -> iREN=1, iaddr=0x40 then 0x44. Next cycle ihit=1, imemload = the word loaded at 0x40. Fetching 0x44 then hits with no iREN.
- iwait held 3 cycles per word during the fill -> iaddr holds 0x40 until the first accept. ihit=0 throughout the fill. Total 9 cycles to ihit.
- Conflict/LRU, defaults: fill 0x000, 0x040, 0x080 (all index 0), with a hit on 0x000 before 0x080 -> 0x040 is evicted. 0x000 and 0x080 hit; 0x040 misses.
- iflush in IDLE after two lines are filled -> both previously hitting addresses miss; iREN rises the cycle after each request.
- iflush during the second word of a fill -> iREN=0 next cycle. The block at 0x40 is not valid; a re-request refetches from 0x40.
- Mid-fill address change: imemaddr moves to 0x100 during the fill of 0x40 -> the fill of 0x40 completes. Then a miss on 0x100 starts, and 0x40 hits afterwards.
